// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and constants for the FIFO read-side stream adapter.
// Sizes the 4-entry prefetch buffer, its pointers and its occupancy count.
package fifo_rd_stream_pkg;

   localparam int unsigned BUF_DEPTH = 4;

   typedef logic [1:0] buf_ptr_t;
   typedef logic [2:0] buf_cnt_t;

endpackage

// File: rtl/fifo_rd_stream_buf.sv
// Prefetch buffer for fifo_rd_stream: 4-entry circular store with push/pop and occupancy count.
// Head entry is presented combinationally; storage clears on reset so the head reads zero.
module fifo_rd_stream_buf
   import fifo_rd_stream_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output buf_cnt_t         count
);

   logic [WIDTH-1:0] mem [BUF_DEPTH];
   buf_ptr_t         wr_ptr;
   buf_ptr_t         rd_ptr;
   logic             pop_ok;

   // A pop against an empty buffer is ignored rather than corrupting the count.
   assign pop_ok    = pop & (count != '0);
   assign head_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 2'd1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 2'd1;
         end
         case ({push, pop_ok})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fifo_rd_stream.sv
// Converts the dual-clock FIFO pop interface into a valid/ready stream via a 4-word prefetch buffer.
// Optional packet framing on out_last is enabled by defining FIFO_RD_STREAM_LAST_EN.
module fifo_rd_stream
   import fifo_rd_stream_pkg::*;
#(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned PKT_LEN = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_rd_data,
   output logic             fifo_rd_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last
);

   if (PKT_LEN < 1) begin : g_bad_pkt_len
      $error("fifo_rd_stream: PKT_LEN must be at least 1");
   end

   logic     inflight;
   buf_cnt_t count;
   buf_cnt_t credit;
   logic     pop;

   // Issue from registered state only, so out_ready never reaches fifo_rd_en.
   assign credit     = count + buf_cnt_t'(inflight);
   assign fifo_rd_en = rst_n & ~fifo_empty & (credit <= 3'd3);
   assign out_valid  = (count != '0);
   assign pop        = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         inflight <= 1'b0;
      end else begin
         inflight <= fifo_rd_en;
      end
   end

   fifo_rd_stream_buf #(
      .WIDTH (WIDTH)
   ) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight),
      .push_data (fifo_rd_data),
      .pop       (pop),
      .head_data (out_data),
      .count     (count)
   );

`ifdef FIFO_RD_STREAM_LAST_EN
   localparam int unsigned BEAT_W = $clog2(PKT_LEN) + 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

   logic [BEAT_W-1:0] beat_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         beat_cnt <= '0;
      end else if (pop) begin
         beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
      end
   end

   assign out_last = out_valid & (beat_cnt == LAST_BEAT);
`else
   assign out_last = 1'b0;
`endif

endmodule
